// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time, hands the word to decode.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready,
   input  logic            redirect_en,
   input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            fetch_fault
`endif
);

   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] { FETCH, WAIT, HOLD, TRAP } fetchState;
`else
   typedef enum logic [1:0] { FETCH, WAIT, HOLD } fetchState;
`endif

   fetchState       state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] redirTarget;
   logic [XLEN-1:0] nextPc;
   logic            reqTag;

   // JALR rule clears bit 0; without the trap, bit 1 is dropped as well.
   always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
      redirTarget = redirect_pc & ~XLEN'(1);
`else
      redirTarget = redirect_pc & ~XLEN'(3);
`endif
      nextPc = redirect_en ? redirTarget : pc + XLEN'(4);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         instr_valid <= 1'b0;
         instr       <= NOP;
         instr_pc    <= RESET_PC;
         reqTag      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fetch_fault <= 1'b0;
`endif
      end else begin
         case (state)
            FETCH: begin
               // Out of reset the request pulse is raised here; after a
               // handshake it was already raised on the way into FETCH.
               if (imem_req) begin
                  imem_req <= 1'b0;
                  state    <= WAIT;
               end else begin
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
                  reqTag    <= 1'b1;
               end
            end
            WAIT: begin
               if (imem_rvalid && reqTag) begin
                  instr       <= imem_rdata;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  reqTag      <= 1'b0;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                  if (redirect_en && redirTarget[1]) begin
                     fetch_fault <= 1'b1;
                     state       <= TRAP;
                  end else begin
                     pc        <= nextPc;
                     imem_req  <= 1'b1;
                     imem_addr <= nextPc;
                     reqTag    <= 1'b1;
                     state     <= FETCH;
                  end
`else
                  pc        <= nextPc;
                  imem_req  <= 1'b1;
                  imem_addr <= nextPc;
                  reqTag    <= 1'b1;
                  state     <= FETCH;
`endif
               end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            TRAP: begin
               imem_req <= 1'b0;
            end
`endif
            default: state <= FETCH;
         endcase
      end
   end

endmodule
